vram_uart_dump: RTL and testbench
=================================

// Module: vram_uart_dump
// PURPOSE
//   Reads a contiguous range of VDP VRAM and streams it byte-by-byte to the host over the UART transmitter.
//   It is the read-back counterpart of the UART-to-VRAM loader and lets the host check a loaded image.
//   Sits between a spare VRAM read port (synchronous RAM) and the uart tx_data/tx_wr/tx_done interface.
//   Keeps a byte count and an 8-bit additive checksum of everything sent.
// PARAMETERS
//   ADDR_WIDTH  14  VRAM address width; addresses wrap modulo 2**ADDR_WIDTH
//   RD_LATENCY  1   cycles from vram_addr change to valid vram_do (1..3)
// PORTS
//   clk         in   1   system clock; all logic on posedge
//   rst         in   1   asynchronous, active-high reset
//   start       in   1   level sampled in S_IDLE only; begins a dump
//   abort       in   1   stops an active dump (see BEHAVIOUR)
//   base_addr   in   14  first VRAM address, captured on start
//   length      in   15  bytes to send, captured on start; 0 = none, max 16384
//   vram_addr   out  14  VRAM read address (registered)
//   vram_do     in   8   VRAM read data, valid RD_LATENCY cycles after vram_addr
//   tx_data     out  8   byte to the UART; held stable from tx_wr until tx_done
//   tx_wr       out  1   one-cycle pulse that starts a UART transmission
//   tx_done     in   1   one-cycle pulse from the UART when a byte has finished
//   busy        out  1   high from the cycle after start is accepted until done
//   done        out  1   one-cycle pulse when all bytes are sent
//   byte_count  out  15  bytes fully sent (tx_done seen) in the current or last dump
//   checksum    out  8   sum mod 256 of bytes fully sent
// BEHAVIOUR
//   Reset: all outputs 0; state S_IDLE. Reset mid-dump abandons the dump immediately.
//   S_IDLE: if start, capture base/length, clear byte_count/checksum, vram_addr<=base_addr.
//     If length==0: pulse done next cycle and stay idle; busy stays 0.
//     Otherwise go to S_READ, busy<=1.
//   S_READ: wait RD_LATENCY cycles, then latch tx_data<=vram_do, tx_wr<=1, go to S_WAIT.
//   S_WAIT: tx_wr forced 0 after one cycle. Stay here until tx_done.
//     On tx_done: byte_count+=1, checksum+=tx_data, vram_addr+=1 (wraps 3FFF->0000).
//     If byte_count+1==length, go to S_FINISH; else go to S_READ.
//   S_FINISH: done<=1 for one cycle, busy<=0, go to S_IDLE. vram_addr/byte_count/checksum hold.
//   Timing, RD_LATENCY=1: start sampled in cycle 0 -> vram_addr valid in cycle 1, tx_wr high in cycle 2.
//     After tx_done in cycle k, the next tx_wr is in cycle k+2+(RD_LATENCY-1).
//   tx_done outside S_WAIT, including the same cycle as tx_wr, is ignored.
//   start while busy is ignored. start held high re-triggers only after S_IDLE is re-entered.
//   abort: any busy state -> S_IDLE next cycle, busy<=0, no done pulse, tx_wr<=0.
//     A byte already handed to the UART still finishes but is not counted.
//     abort has priority over tx_done in the same cycle. abort in S_IDLE does nothing.
//   tx_data changes only when tx_wr is asserted.
// TESTING
//   1 base=0x0100, length=4, VRAM[0x100..0x103]=11,22,33,44; UART model tx_done 10 cycles after tx_wr
//     -> tx bytes 11,22,33,44 in order, four tx_wr pulses, done once, byte_count=4, checksum=0xAA.
//   2 base=0x3FFE, length=3, VRAM[3FFE]=01,[3FFF]=02,[0000]=03 -> bytes 01,02,03; final vram_addr=0x0001.
//   3 length=0 -> done pulses the cycle after start; no tx_wr; busy never high; byte_count=0.
//   4 length=8, abort on the cycle of the 3rd tx_wr -> idle next cycle, no done, byte_count=2, busy=0.
//   5 start re-pulsed mid-dump, plus a spurious tx_done in S_READ -> both ignored; a 4-byte dump sends exactly 4 bytes.
//   6 rst asserted mid-dump, then a new dump of length 2 -> outputs 0 during reset;
//     the new dump completes normally with checksum of the 2 bytes.
//   Run all six with RD_LATENCY=1 and 3; check the start-to-tx_wr latency is 1+RD_LATENCY cycles.

Source files
------------

// File: rtl/vram_uart_dump.sv
// Streams a contiguous VRAM range to the UART transmitter one byte at a time,
// keeping a count of the bytes fully sent and their 8-bit additive checksum.
module vram_uart_dump #(
    parameter int ADDR_WIDTH = 14,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    input  logic [7:0]            vram_do,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   byte_count,
    output logic [7:0]            checksum
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]      CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]            LAT_LAST  = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_READ   = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                state_r,      state_s;
    logic [ADDR_WIDTH-1:0] vram_addr_r,  vram_addr_s;
    logic [CNT_W-1:0]      length_r,     length_s;
    logic [CNT_W-1:0]      byte_count_r, byte_count_s;
    logic [7:0]            checksum_r,   checksum_s;
    logic [7:0]            tx_data_r,    tx_data_s;
    logic                  tx_wr_r,      tx_wr_s;
    logic                  busy_r,       busy_s;
    logic                  done_r,       done_s;
    logic [1:0]            lat_r,        lat_s;
    logic [CNT_W-1:0]      cnt_inc_s;

    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

    assign cnt_inc_s = byte_count_r + CNT_ONE;

    // Next-state and next-register values for the dump sequencer.
    always_comb begin
        state_s      = state_r;
        vram_addr_s  = vram_addr_r;
        length_s     = length_r;
        byte_count_s = byte_count_r;
        checksum_s   = checksum_r;
        tx_data_s    = tx_data_r;
        tx_wr_s      = 1'b0;
        busy_s       = busy_r;
        done_s       = 1'b0;
        lat_s        = lat_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    vram_addr_s  = base_addr;
                    length_s     = length;
                    byte_count_s = CNT_ZERO;
                    checksum_s   = 8'h00;
                    lat_s        = 2'd0;
                    if (length == CNT_ZERO) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = S_READ;
                        busy_s  = 1'b1;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end else if (lat_r == LAT_LAST) begin
                    tx_data_s = vram_do;
                    tx_wr_s   = 1'b1;
                    lat_s     = 2'd0;
                    state_s   = S_WAIT;
                end else begin
                    lat_s = lat_r + 2'd1;
                end
            end
            S_WAIT: begin
                // tx_done in the tx_wr cycle belongs to no byte of ours yet
                if (abort) begin
                    state_s = S_IDLE;
                    busy_s  = 1'b0;
                end else if (tx_done && !tx_wr_r) begin
                    byte_count_s = cnt_inc_s;
                    checksum_s   = csum_add(checksum_r, tx_data_r);
                    vram_addr_s  = vram_addr_r + ADDR_ONE;
                    lat_s        = 2'd0;
                    if (cnt_inc_s == length_r) begin
                        state_s = S_FINISH;
                    end else begin
                        state_s = S_READ;
                    end
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
                if (abort) begin
                    done_s = 1'b0;
                end else begin
                    done_s = 1'b1;
                end
            end
            default: begin
                state_s = S_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any dump in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_IDLE;
            vram_addr_r  <= {ADDR_WIDTH{1'b0}};
            length_r     <= CNT_ZERO;
            byte_count_r <= CNT_ZERO;
            checksum_r   <= 8'h00;
            tx_data_r    <= 8'h00;
            tx_wr_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            lat_r        <= 2'd0;
        end else begin
            state_r      <= state_s;
            vram_addr_r  <= vram_addr_s;
            length_r     <= length_s;
            byte_count_r <= byte_count_s;
            checksum_r   <= checksum_s;
            tx_data_r    <= tx_data_s;
            tx_wr_r      <= tx_wr_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            lat_r        <= lat_s;
        end
    end

    assign vram_addr  = vram_addr_r;
    assign tx_data    = tx_data_r;
    assign tx_wr      = tx_wr_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign byte_count = byte_count_r;
    assign checksum   = checksum_r;

endmodule

// File: tb/tb_vram_uart_dump.sv
// Bench for vram_uart_dump: two instances (read latency 1 and 3), each with a VRAM
// and UART model; a byte scoreboard plus a table of dumps and a few hand-built sequences.
module tb_vram_uart_dump;

    typedef struct {
        logic [13:0] base;
        logic [14:0] len;
        int          abort_wr;
        bit          disturb;
        logic [7:0]  exp_sum;
        logic [13:0] exp_addr;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v [2];
    logic        start_v [2];
    logic        abort_v [2];
    logic        inj_v [2];
    logic [13:0] base_v [2];
    logic [14:0] len_v [2];
    logic [13:0] addr_v [2];
    logic [7:0]  vram_do_v [2];
    logic [7:0]  tx_data_v [2];
    logic        tx_wr_v [2];
    logic        tx_done_v [2];
    logic        uart_done_v [2];
    logic        busy_v [2];
    logic        done_v [2];
    logic [14:0] byte_count_v [2];
    logic [7:0]  checksum_v [2];

    logic [7:0] mem [16384];
    logic [7:0] exp_q [$];
    vec_t       tbl [7];
    vec_t       after_rst;
    int         n_vec = 0;
    int         n_bad = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [7:0] p0;
        logic [7:0] p1;
        int         cd;

        vram_uart_dump #(.ADDR_WIDTH(14), .RD_LATENCY(LAT)) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .start      (start_v[g]),
            .abort      (abort_v[g]),
            .base_addr  (base_v[g]),
            .length     (len_v[g]),
            .vram_addr  (addr_v[g]),
            .vram_do    (vram_do_v[g]),
            .tx_data    (tx_data_v[g]),
            .tx_wr      (tx_wr_v[g]),
            .tx_done    (tx_done_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g]),
            .byte_count (byte_count_v[g]),
            .checksum   (checksum_v[g])
        );

        // VRAM read pipeline: data is sampled LAT edges after the address changes
        always @(posedge clk) begin
            p0 <= mem[addr_v[g]];
            p1 <= p0;
        end
        assign vram_do_v[g] = (LAT == 1) ? mem[addr_v[g]] : ((LAT == 2) ? p0 : p1);

        // UART model: tx_done pulses 10 cycles after tx_wr
        always @(posedge clk) begin
            if (rst_v[g]) cd <= 0;
            else if (tx_wr_v[g]) cd <= 10;
            else if (cd > 0) cd <= cd - 1;
        end
        assign uart_done_v[g] = (cd == 1);
        assign tx_done_v[g]   = uart_done_v[g] | inj_v[g];
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic logic [63:0] outs(input int d);
        return {16'd0, addr_v[d], tx_data_v[d], tx_wr_v[d], busy_v[d], done_v[d],
                byte_count_v[d], checksum_v[d]};
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (RD_LATENCY=%0d): got 0x%0h, expected 0x%0h", name, lat_of(d), act, exp);
        end
    endtask

    task automatic run_vec(input int d, input vec_t v);
        int wr_exp, cnt_exp, done_exp;
        int wr_seen = 0, done_seen = 0, done_cyc = -1, first_wr = -1, last_wr = -100;
        int busy_hi = 0, pending = 0, stable_bad = 0, quiet = 0, abort_cyc = -100;
        int since_done = 100;
        logic [7:0] held = 8'h00;
        wr_exp   = (v.abort_wr > 0) ? v.abort_wr : int'(v.len);
        cnt_exp  = (v.abort_wr > 0) ? v.abort_wr - 1 : int'(v.len);
        done_exp = (v.abort_wr > 0) ? 0 : 1;
        exp_q.delete();
        for (int i = 0; i < wr_exp; i++) exp_q.push_back(mem[14'(int'(v.base) + i)]);
        base_v[d]  = v.base;
        len_v[d]   = v.len;
        start_v[d] = 1'b1;
        @(negedge clk);
        for (int cyc = 1; cyc < 3000 && quiet < 12; cyc++) begin
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            inj_v[d]   = 1'b0;
            // Spurious tx_done in S_READ and in the tx_wr cycle; start re-pulses mid-dump
            if (v.disturb && wr_seen == 1 && since_done <= lat_of(d)) inj_v[d] = 1'b1;
            if (v.disturb && ((wr_seen == 1 && since_done == 0) || (wr_seen == 2 && cyc == last_wr + 2))) begin
                start_v[d] = 1'b1;
                base_v[d]  = 14'h2AAA;
                len_v[d]   = 15'd1;
            end
            if (busy_v[d]) busy_hi = 1;
            if (cyc == abort_cyc + 1) chk("busy_after_abort", d, busy_v[d], 0);
            if (tx_wr_v[d]) begin
                wr_seen++;
                last_wr = cyc;
                if (first_wr < 0) first_wr = cyc;
                if (exp_q.size() == 0) chk("extra_tx_wr", d, wr_seen, wr_exp);
                else chk("tx_byte", d, tx_data_v[d], exp_q.pop_front());
                held    = tx_data_v[d];
                pending = 1;
                if (wr_seen == v.abort_wr) begin
                    abort_v[d] = 1'b1;
                    abort_cyc  = cyc;
                end
            end else if (pending != 0 && tx_data_v[d] !== held) begin
                stable_bad = 1;
            end
            if (uart_done_v[d]) begin
                pending    = 0;
                since_done = 0;
            end else begin
                since_done++;
            end
            if (done_v[d]) begin
                done_seen++;
                done_cyc = cyc;
            end
            if (!busy_v[d] && pending == 0 && !tx_wr_v[d] && cyc > 1) quiet++;
            else quiet = 0;
            @(negedge clk);
        end
        start_v[d] = 1'b0;
        abort_v[d] = 1'b0;
        inj_v[d]   = 1'b0;
        chk("settled", d, quiet, 12);
        chk("tx_wr_count", d, wr_seen, wr_exp);
        chk("done_count", d, done_seen, done_exp);
        chk("byte_count", d, byte_count_v[d], cnt_exp);
        chk("checksum", d, checksum_v[d], v.exp_sum);
        chk("vram_addr", d, addr_v[d], v.exp_addr);
        chk("busy_seen", d, busy_hi, (v.len != 15'd0) ? 1 : 0);
        chk("tx_data_stable", d, stable_bad, 0);
        chk("scoreboard_left", d, exp_q.size(), 0);
        if (wr_exp > 0) chk("start_to_tx_wr", d, first_wr, 1 + lat_of(d));
        else chk("zero_len_done_cycle", d, done_cyc, 1);
    endtask

    task automatic reset_mid(input int d);
        int wr_seen = 0;
        int budget  = 0;
        base_v[d]  = 14'h0400;
        len_v[d]   = 15'd8;
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        while (wr_seen < 2 && budget < 500) begin
            if (tx_wr_v[d]) wr_seen++;
            budget++;
            @(negedge clk);
        end
        chk("reset_mid_reached", d, wr_seen, 2);
        rst_v[d] = 1'b1;
        #1;
        chk("outputs_at_reset", d, outs(d), 64'd0);
        repeat (3) @(negedge clk);
        chk("outputs_in_reset", d, outs(d), 64'd0);
        rst_v[d] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[14'h0100] = 8'h11;
        mem[14'h0101] = 8'h22;
        mem[14'h0102] = 8'h33;
        mem[14'h0103] = 8'h44;
        mem[14'h3FFE] = 8'h01;
        mem[14'h3FFF] = 8'h02;
        mem[14'h0000] = 8'h03;
        tbl[0] = '{base: 14'h0100, len: 15'd4, abort_wr: 0, disturb: 1'b0, exp_sum: 8'hAA, exp_addr: 14'h0104};
        tbl[1] = '{base: 14'h3FFE, len: 15'd3, abort_wr: 0, disturb: 1'b0, exp_sum: 8'h06, exp_addr: 14'h0001};
        tbl[2] = '{base: 14'h0050, len: 15'd0, abort_wr: 0, disturb: 1'b0, exp_sum: 8'h00, exp_addr: 14'h0050};
        tbl[3] = '{base: 14'h0200, len: 15'd8, abort_wr: 3, disturb: 1'b0, exp_sum: 8'hB5, exp_addr: 14'h0202};
        tbl[4] = '{base: 14'h0300, len: 15'd4, abort_wr: 0, disturb: 1'b1, exp_sum: 8'h66, exp_addr: 14'h0304};
        tbl[5] = '{base: 14'h1234, len: 15'd1, abort_wr: 0, disturb: 1'b0, exp_sum: 8'h6E, exp_addr: 14'h1235};
        tbl[6] = '{base: 14'h3FFF, len: 15'd2, abort_wr: 0, disturb: 1'b0, exp_sum: 8'h05, exp_addr: 14'h0001};
        after_rst = '{base: 14'h0500, len: 15'd2, abort_wr: 0, disturb: 1'b0, exp_sum: 8'hB5, exp_addr: 14'h0502};
        for (int d = 0; d < 2; d++) begin
            rst_v[d]   = 1'b1;
            start_v[d] = 1'b0;
            abort_v[d] = 1'b0;
            inj_v[d]   = 1'b0;
            base_v[d]  = 14'h0000;
            len_v[d]   = 15'd0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) chk("reset_state", d, outs(d), 64'd0);
        for (int d = 0; d < 2; d++) rst_v[d] = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 7; r++) run_vec(d, tbl[r]);
            reset_mid(d);
            run_vec(d, after_rst);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
